// File: rtl/ram_1rw_arbiter_pkg.sv
// Shared constants for the single-port RAM arbiter: idle RAM-port values and index-width helper.
// Combinational helpers only; no latency, no flow control.
package ram_1rw_arbiter_pkg;

  localparam logic RAM_CS_N_IDLE = 1'b1;
  localparam logic RAM_WE_N_IDLE = 1'b0;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ram_1rw_arbiter_rr_pick.sv
// rr_pick: round-robin pick of the first set request at or after i_ptr, as one-hot grant plus index.
// Purely combinational (zero latency); no backpressure, caller decides whether the grant is used.
module rr_pick #(
  parameter int NREQ = 2,
  parameter int IW   = 1
) (
  input  logic [NREQ-1:0] i_req,
  input  logic [IW-1:0]   i_ptr,
  output logic [NREQ-1:0] o_gnt,
  output logic [IW-1:0]   o_idx,
  output logic            o_any
);

  logic [IW:0]   w_sum;
  logic [IW-1:0] w_k;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_sum = '0;
    w_k   = '0;
    for (int i = 0; i < NREQ; i++) begin
      // ptr is always < NREQ, so one conditional subtract wraps the search index
      w_sum = {1'b0, i_ptr} + (IW+1)'(i);
      if (w_sum >= (IW+1)'(NREQ)) w_sum = w_sum - (IW+1)'(NREQ);
      w_k = w_sum[IW-1:0];
      if (!o_any && i_req[w_k]) begin
        o_any      = 1'b1;
        o_gnt[w_k] = 1'b1;
        o_idx      = w_k;
      end
    end
  end

endmodule

// File: rtl/ram_1rw_arbiter.sv
// Round-robin sharing of one single-port RAM among NREQ requesters; optional burst lock via RAM_ARB_LOCK_EN.
// Grant and RAM access in the request cycle; read data/rvalid one cycle later. Losers hold i_req until granted.
module ram_1rw_arbiter
  import ram_1rw_arbiter_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int DEPTH  = 64,
  parameter int DWIDTH = 32,
  localparam int AWIDTH = $clog2(DEPTH),
  localparam int MWIDTH = DWIDTH / 8
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic [NREQ-1:0]          i_req,
  input  logic [NREQ-1:0]          i_we_n,
  input  logic [NREQ*MWIDTH-1:0]   i_wmask,
  input  logic [NREQ*AWIDTH-1:0]   i_addr,
  input  logic [NREQ*DWIDTH-1:0]   i_wdata,
  input  logic [NREQ-1:0]          i_lock,
  output logic [NREQ-1:0]          o_gnt,
  output logic [NREQ-1:0]          o_rvalid,
  output logic [DWIDTH-1:0]        o_rdata,
  output logic                     o_ram_cs_n,
  output logic                     o_ram_we_n,
  output logic [MWIDTH-1:0]        o_ram_wmask,
  output logic [AWIDTH-1:0]        o_ram_addr,
  output logic [DWIDTH-1:0]        o_ram_wdata,
  input  logic [DWIDTH-1:0]        i_ram_rdata
);

  localparam int IW = idx_width(NREQ);

  logic [IW-1:0]   r_ptr;
  logic [NREQ-1:0] r_rvalid;

  logic [NREQ-1:0] w_rr_gnt;
  logic [IW-1:0]   w_rr_idx;
  logic            w_rr_any;
  logic [NREQ-1:0] w_sel_gnt;
  logic [IW-1:0]   w_sel_idx;
  logic            w_sel_any;
  logic [NREQ-1:0] w_gnt;
  logic [IW-1:0]   w_idx;
  logic            w_any;

  rr_pick #(.NREQ(NREQ), .IW(IW)) u_pick (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_gnt (w_rr_gnt),
    .o_idx (w_rr_idx),
    .o_any (w_rr_any)
  );

`ifdef RAM_ARB_LOCK_EN
  logic          r_lock_vld;
  logic [IW-1:0] r_lock_owner;
  logic          w_lock_hold;

  assign w_lock_hold = r_lock_vld & i_req[r_lock_owner] & i_lock[r_lock_owner];

  always_comb begin
    w_sel_gnt = w_rr_gnt;
    w_sel_idx = w_rr_idx;
    w_sel_any = w_rr_any;
    if (w_lock_hold) begin
      w_sel_gnt               = '0;
      w_sel_gnt[r_lock_owner] = 1'b1;
      w_sel_idx               = r_lock_owner;
      w_sel_any               = 1'b1;
    end
  end

  // any idle cycle or unlocked grant releases the lock
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_lock_vld   <= 1'b0;
      r_lock_owner <= '0;
    end else begin
      r_lock_vld <= w_any & i_lock[w_idx];
      if (w_any) r_lock_owner <= w_idx;
    end
  end
`else
  logic w_unused_lock;
  assign w_unused_lock = ^i_lock;

  always_comb begin
    w_sel_gnt = w_rr_gnt;
    w_sel_idx = w_rr_idx;
    w_sel_any = w_rr_any;
  end
`endif

  assign w_gnt = w_sel_gnt & {NREQ{~i_rst}};
  assign w_any = w_sel_any & ~i_rst;
  assign w_idx = w_sel_idx;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_ptr    <= '0;
      r_rvalid <= '0;
    end else begin
      r_rvalid <= w_gnt & i_we_n;
      if (w_any) r_ptr <= (w_idx == IW'(NREQ - 1)) ? '0 : w_idx + IW'(1);
    end
  end

  always_comb begin
    o_ram_cs_n  = RAM_CS_N_IDLE;
    o_ram_we_n  = RAM_WE_N_IDLE;
    o_ram_wmask = '0;
    o_ram_addr  = '0;
    o_ram_wdata = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (w_gnt[k]) begin
        o_ram_cs_n  = 1'b0;
        o_ram_we_n  = i_we_n[k];
        o_ram_wmask = i_wmask[k*MWIDTH +: MWIDTH];
        o_ram_addr  = i_addr[k*AWIDTH +: AWIDTH];
        o_ram_wdata = i_wdata[k*DWIDTH +: DWIDTH];
      end
    end
  end

  assign o_gnt    = w_gnt;
  assign o_rvalid = r_rvalid;
  assign o_rdata  = i_ram_rdata;

endmodule
